serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial adder built around the team's half-adder cell. Per bit: two `ha` instances plus an OR form a full adder, and a registered carry links successive bits.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Adds LSB-first, one bit per clock, then presents the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits downstream of the operand source and directly consumes the half-adder sum/carry outputs each cycle.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal values: WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b and cin are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  bit WIDTH of a + b + cin.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset state, asserted immediately on rst_n low:
  - state = IDLE; out_valid = 0; sum = 0; cout = 0; busy = 0.
  - in_ready = 1 (decoded from IDLE).
  - shift registers, carry register and counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at an edge: load a_sr <= a, b_sr <= b, c_reg <= cin, cnt <= 0; next state RUN.
- RUN, one bit per cycle:
  - s = a_sr[0] ^ b_sr[0] ^ c_reg.
  - c_next = majority(a_sr[0], b_sr[0], c_reg).
  - s_sr shifts right with s entering at the MSB; a_sr and b_sr shift right; c_reg <= c_next; cnt++.
  - When cnt == WIDTH-1 at the edge: sum <= final s_sr, cout <= c_next; next state DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE:
  - out_valid = 1; sum and cout held stable.
  - On out_valid && out_ready: next state IDLE, out_valid = 0.
  - sum and cout keep their last value until the next completion.
- Latency:
  - Operands accepted at edge T0 give out_valid high after edge T0+WIDTH.
  - Minimum spacing between acceptances is WIDTH+2 cycles (RUN, DONE, IDLE).
  - No accept in the same cycle as a result handoff.
- Handshake rules:
  - in_valid, a, b and cin are ignored outside IDLE.
  - out_valid never drops without out_ready.
  - out_ready is ignored outside DONE.
- Arithmetic:
  - Result wraps modulo 2^WIDTH; overflow is reported only via cout.
  - Counter width is ceil(log2(WIDTH))+1 bits, with no wrap inside RUN.
- Reset mid-operation (RUN or DONE):
  - Operation aborted, return to reset state, no out_valid pulse.
  - Next accepted operation computes correctly with no residue.
- Simultaneous in_valid and rst_n deassertion edge: no accept in that cycle.
- Outputs are registered except in_ready and busy, which are state decodes.

Test Plan:
1. Reset: rst_n = 0 mid-sim with in_valid = 1 -> immediately out_valid = 0, sum = 8'h00, cout = 0, busy = 0, in_ready = 1. No acceptance until after rst_n rises.
2. Basic add: a = 8'h01, b = 8'h01, cin = 0 -> out_valid exactly 8 cycles after accept, sum = 8'h02, cout = 0. Then a = 8'h00, b = 8'h00, cin = 0 -> sum = 8'h00, cout = 0.
3. Full carry ripple:
   - a = 8'hFF, b = 8'h01, cin = 0 -> sum = 8'h00, cout = 1.
   - a = 8'hFF, b = 8'hFF, cin = 1 -> sum = 8'hFF, cout = 1.
4. Backpressure:
   - Hold out_ready = 0 for 5 cycles after out_valid -> out_valid, sum and cout stable; in_ready = 0; in_valid pulses with a = 8'h33 are ignored.
   - Then out_ready = 1 -> IDLE on the next cycle.
5. Reset during RUN:
   - Pulse rst_n low in RUN cycle 3 -> IDLE, out_valid never asserted.
   - Then a = 8'h5A, b = 8'hA5, cin = 1 -> sum = 8'h00, cout = 1.
6. Back-to-back: out_ready tied 1, in_valid held 1 with ops (8'h12, 8'h34, 0) then (8'h80, 8'h80, 0):
   - Results 8'h46 / cout 0, then 8'h00 / cout 1.
   - Acceptances exactly WIDTH+2 = 10 cycles apart.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// master is the operand source / result consumer, slave is the adder itself.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: a full adder built from two half-adder cells
// plus a registered carry processes one bit per clock between two handshakes.
module ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, sum_reg;
  logic [WIDTH-2:0] s_sr_reg, s_sr_next;
  logic             c_reg, cout_reg, out_valid_reg;
  logic [CW-1:0]    cnt_reg;
  logic             ha0_s, ha0_c, bit_s, ha1_c, c_next;
  logic             accept, last_bit, handoff;
  logic             ready_dec, busy_dec;

  ha u_ha0 (.x(a_sr_reg[0]), .y(b_sr_reg[0]), .s(ha0_s), .c(ha0_c));
  ha u_ha1 (.x(ha0_s),       .y(c_reg),       .s(bit_s), .c(ha1_c));
  assign c_next = ha0_c | ha1_c;

  assign accept   = (state_reg == IDLE) && bus.in_valid;
  assign last_bit = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));
  assign handoff  = (state_reg == DONE) && bus.out_ready;

  // Partial sum keeps only the WIDTH-1 bits already produced; the final bit
  // is merged straight into the result on the last RUN cycle.
  generate
    if (WIDTH > 2) begin : g_wide
      assign s_sr_next = {bit_s, s_sr_reg[WIDTH-2:1]};
    end else begin : g_narrow
      assign s_sr_next = bit_s;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_bit)      state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_dec = 1'b0;
    busy_dec  = 1'b0;
    case (state_reg)
      IDLE:    ready_dec = 1'b1;
      RUN:     busy_dec  = 1'b1;
      DONE:    busy_dec  = 1'b1;
      default: ready_dec = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_reg      <= '0;
      b_sr_reg      <= '0;
      s_sr_reg      <= '0;
      c_reg         <= 1'b0;
      cnt_reg       <= '0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      a_sr_reg <= bus.a;
      b_sr_reg <= bus.b;
      c_reg    <= bus.cin;
      cnt_reg  <= '0;
      s_sr_reg <= '0;
    end else if (state_reg == RUN) begin
      a_sr_reg <= {1'b0, a_sr_reg[WIDTH-1:1]};
      b_sr_reg <= {1'b0, b_sr_reg[WIDTH-1:1]};
      c_reg    <= c_next;
      cnt_reg  <= cnt_reg + 1'b1;
      s_sr_reg <= s_sr_next;
      if (last_bit) begin
        sum_reg       <= {bit_s, s_sr_reg};
        cout_reg      <= c_next;
        out_valid_reg <= 1'b1;
      end
    end else if (handoff) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = ready_dec;
  assign bus.busy      = busy_dec;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
endmodule
